// File: rtl/vdp_color_palette.sv
// VDP colour-output stage: maps 5-bit pixel indices through CRAM to 4:4:4 VGA RGB
// and handles CPU CRAM writes in Game Gear (two-byte latched) and SMS (6-bit) formats.
module vdp_color_palette #(
    parameter int CRAM_ENTRIES = 32,
    parameter int CH_BITS      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          color_idx,
    input  logic                de,
    input  logic                active,
    input  logic [3:0]          backdrop_idx,
    input  logic                gg_mode,
    input  logic                cram_we,
    input  logic [5:0]          cram_addr,
    input  logic [7:0]          cram_din,
    output logic [CH_BITS-1:0]  vga_r,
    output logic [CH_BITS-1:0]  vga_g,
    output logic [CH_BITS-1:0]  vga_b
);

    localparam int ENTRY_W = 3 * CH_BITS;

    // Entry layout is {B, G, R}
    logic [ENTRY_W-1:0] cram [CRAM_ENTRIES];
    logic [7:0]         gg_latch;

    logic [4:0]         s1_idx;
    logic               s1_de;
    logic               s1_active;
    logic [3:0]         s1_backdrop;

    logic [4:0]         eff_idx;
    logic [ENTRY_W-1:0] eff_entry;
    logic [ENTRY_W-1:0] sms_entry;

    always_comb begin
        sms_entry = {{2{cram_din[5:4]}}, {2{cram_din[3:2]}}, {2{cram_din[1:0]}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CRAM_ENTRIES; i++) begin
                cram[i] <= '0;
            end
            gg_latch <= '0;
        end else if (cram_we) begin
            if (gg_mode) begin
                if (!cram_addr[0]) begin
                    gg_latch <= cram_din;
                end else begin
                    cram[cram_addr[5:1]] <= {cram_din[3:0], gg_latch};
                end
            end else begin
                cram[cram_addr[4:0]] <= sms_entry;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_idx      <= '0;
            s1_de       <= 1'b0;
            s1_active   <= 1'b0;
            s1_backdrop <= '0;
        end else begin
            s1_idx      <= color_idx;
            s1_de       <= de;
            s1_active   <= active;
            s1_backdrop <= backdrop_idx;
        end
    end

    // Stage 2 reads CRAM after any write committed on the stage-1 sampling edge
    always_comb begin
        eff_idx   = s1_active ? s1_idx : {1'b1, s1_backdrop};
        eff_entry = cram[eff_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (!s1_de) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else begin
            vga_r <= eff_entry[CH_BITS-1:0];
            vga_g <= eff_entry[2*CH_BITS-1:CH_BITS];
            vga_b <= eff_entry[3*CH_BITS-1:2*CH_BITS];
        end
    end

endmodule

// File: doc/vdp_color_palette.md
Name: vdp_color_palette

Overview:
Colour-output stage directly downstream of the VDP background generator. It takes the 5-bit per-pixel colour index and maps it through on-chip colour RAM (CRAM) to 4-bit-per-channel VGA RGB, with blanking and border/backdrop handling. It also owns CPU writes into CRAM, in both Game Gear (12-bit, two-byte latched) and Master System (6-bit, single-byte) formats.

Parameters:
CRAM_ENTRIES, 32, number of palette entries (index width 5 bits)
CH_BITS, 4, output bits per colour channel

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
color_idx  in  5  pixel colour index from background stage; bit 4 selects sprite palette
de  in  1  VGA display enable for this pixel (0 = blanking)
active  in  1  pixel lies inside the VDP active window (1 = show color_idx; 0 = border)
backdrop_idx  in  4  backdrop colour, taken from sprite palette (entry 16+backdrop_idx)
gg_mode  in  1  1 = Game Gear CRAM format, 0 = SMS format
cram_we  in  1  one-cycle CRAM byte write strobe
cram_addr  in  6  CRAM byte address
cram_din  in  8  CRAM write data
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue

Behaviour:
- Reset (async, rst=1): all CRAM entries cleared to 12'h000; write latch cleared to 8'h00; pipeline registers and vga_r/g/b go to 0 immediately. Reset mid-frame forces black on the same cycle.
- CRAM storage: 32 x 12 bits, {B[3:0], G[3:0], R[3:0]}.
- GG write (gg_mode=1), qualified by cram_we:
  - Even cram_addr: latch <= cram_din. CRAM unchanged.
  - Odd cram_addr: entry[cram_addr[5:1]] <= {cram_din[3:0], latch}. cram_din[7:4] ignored.
  - An even write followed by another even write overwrites the latch.
  - An odd write with no preceding even write commits the current latch value (reset value 0).
- SMS write (gg_mode=0): entry[cram_addr[4:0]] <= {bb,bb,gg,gg,rr,rr}, where rr=cram_din[1:0], gg=[3:2], bb=[5:4]. Each 2-bit value is replicated to 4 bits. cram_addr[5] and cram_din[7:6] are ignored; the latch is untouched.
- Toggling gg_mode does not clear the latch or CRAM.
- Pixel pipeline, fixed latency of 2 clocks:
  - Stage 1 registers color_idx, de, active and backdrop_idx.
  - Stage 2 selects the effective index, reads CRAM and registers RGB.
- Output select in stage 2:
  - de=0 → 0,0,0.
  - de=1 and active=0 → entry[16+backdrop_idx].
  - Otherwise → entry[color_idx].
- Write/read ordering: a CRAM commit at clock edge E is visible to any pixel sampled into stage 1 at edge E or later. Pixels sampled before E show the old value. Writes never stall or disturb the pixel pipeline.
- Under continuous input, one pixel is output per clock with no bubbles.

Test Plan:
- Reset: assert rst mid-stream with de=1 → vga_r/g/b = 0 in the same cycle. After release, every entry reads 12'h000 (black for any idx).
- GG write: gg_mode=1, write addr 6 data 8'h5A, then addr 7 data 8'hF3. Then drive idx=3, de=1, active=1 → after 2 clocks R=A, G=5, B=3.
- SMS write: gg_mode=0, write addr 2 data 8'h39 (bb=11, gg=10, rr=01). Then idx=2 → R=5, G=A, B=F.
- Border, blanking, latency:
  - Load entry 21 = 12'h0F0. Drive active=0, backdrop_idx=5, de=1 → G=F, R=B=0.
  - Drop de for one pixel → exactly one black output, 2 cycles later.
- Write/read collision: stream idx=4 continuously while committing entry 4 from 12'h000 to 12'hFFF at edge E. Outputs for pixels sampled before E are 0; outputs from pixel E onward are F,F,F (visible at E+2).
- Latch edge case: GG odd write to addr 9 data 8'h01 after reset, with no even write → entry 4 = 12'h100 (B=1, G=0, R=0).
